// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   // IE operand source select
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_WB = 2'b01,
      FWD_IM = 2'b10
   } fwd_sel_e;

   // Hazard FSM states
   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hz_state_e;

   // Width of the load-use bubble counter; holds LOAD_LATENCY up to 15
   localparam int unsigned LuCntWidth = 4;

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one IE operand: IM result beats WB result beats register file.
module fwd_sel_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic [REG_ADDR_WIDTH-1:0] i_src_reg,
   input  logic [REG_ADDR_WIDTH-1:0] i_IM_dst_reg,
   input  logic                      i_IM_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] i_WB_dst_reg,
   input  logic                      i_WB_wr_en,
   output fwd_sel_e                  o_fwd_sel
);

   logic im_hit;
   logic wb_hit;

   // x0 is hardwired zero, so a write to it never produces a forwardable value
   assign im_hit = i_IM_wr_en && (i_IM_dst_reg != '0) && (i_IM_dst_reg == i_src_reg);
   assign wb_hit = i_WB_wr_en && (i_WB_dst_reg != '0) && (i_WB_dst_reg == i_src_reg);

   // Younger (IM) result takes priority over older (WB) result
   always_comb begin
      o_fwd_sel = FWD_RF;
      if (im_hit) begin
         o_fwd_sel = FWD_IM;
      end else if (wb_hit) begin
         o_fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stalls, redirect flushes,
// data-memory freeze and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned LOAD_LATENCY   = 1,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [REG_ADDR_WIDTH-1:0] i_ID_src_reg_1,
   input  logic [REG_ADDR_WIDTH-1:0] i_ID_src_reg_2,
   input  logic                      i_ID_use_src_1,
   input  logic                      i_ID_use_src_2,
   input  logic [REG_ADDR_WIDTH-1:0] i_IE_src_reg_1,
   input  logic [REG_ADDR_WIDTH-1:0] i_IE_src_reg_2,
   input  logic [REG_ADDR_WIDTH-1:0] i_IE_dst_reg,
   input  logic [REG_ADDR_WIDTH-1:0] i_IM_dst_reg,
   input  logic [REG_ADDR_WIDTH-1:0] i_WB_dst_reg,
   input  logic                      i_ctrl_IE_reg_wr_en,
   input  logic                      i_ctrl_IM_reg_wr_en,
   input  logic                      i_ctrl_WB_reg_wr_en,
   input  logic                      i_IE_is_load,
   input  logic                      i_IE_redirect,
   input  logic                      i_dmem_busy,
   input  logic                      i_cnt_clr,
   output logic [1:0]                o_fwd_sel_1,
   output logic [1:0]                o_fwd_sel_2,
   output logic                      o_stall_IF,
   output logic                      o_stall_ID,
   output logic                      o_stall_IE,
   output logic                      o_stall_IM,
   output logic                      o_flush_ID,
   output logic                      o_flush_IE,
   output logic                      o_flush_WB,
   output logic [CNT_WIDTH-1:0]      o_stall_cycles
);

   localparam logic [LuCntWidth-1:0] LuCntInit = LuCntWidth'(LOAD_LATENCY - 1);

   hz_state_e             state_q, state_d;
   logic [LuCntWidth-1:0] lu_cnt_q, lu_cnt_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   fwd_sel_e sel_1;
   fwd_sel_e sel_2;
   logic     lu_hit;
   logic     stall_if, stall_id, stall_ie, stall_im;
   logic     flush_id, flush_ie, flush_wb;

   fwd_sel_unit #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_fwd_1 (
      .i_src_reg    (i_IE_src_reg_1),
      .i_IM_dst_reg (i_IM_dst_reg),
      .i_IM_wr_en   (i_ctrl_IM_reg_wr_en),
      .i_WB_dst_reg (i_WB_dst_reg),
      .i_WB_wr_en   (i_ctrl_WB_reg_wr_en),
      .o_fwd_sel    (sel_1)
   );

   fwd_sel_unit #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_fwd_2 (
      .i_src_reg    (i_IE_src_reg_2),
      .i_IM_dst_reg (i_IM_dst_reg),
      .i_IM_wr_en   (i_ctrl_IM_reg_wr_en),
      .i_WB_dst_reg (i_WB_dst_reg),
      .i_WB_wr_en   (i_ctrl_WB_reg_wr_en),
      .o_fwd_sel    (sel_2)
   );

   // Load in IE whose result a used ID source needs before it exists
   assign lu_hit = i_IE_is_load && i_ctrl_IE_reg_wr_en && (i_IE_dst_reg != '0) &&
                   ((i_ID_use_src_1 && (i_ID_src_reg_1 == i_IE_dst_reg)) ||
                    (i_ID_use_src_2 && (i_ID_src_reg_2 == i_IE_dst_reg)));

   // Next state and stall/flush outputs; priority is freeze, redirect, load-use
   always_comb begin
      state_d  = state_q;
      lu_cnt_d = lu_cnt_q;
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ie = 1'b0;
      stall_im = 1'b0;
      flush_id = 1'b0;
      flush_ie = 1'b0;
      flush_wb = 1'b0;
      if (i_reset) begin
         state_d  = RUN;
         lu_cnt_d = '0;
      end else if (i_dmem_busy) begin
         // Whole pipe holds; only a bubble enters WB, FSM and bubble count freeze
         stall_if = 1'b1;
         stall_id = 1'b1;
         stall_ie = 1'b1;
         stall_im = 1'b1;
         flush_wb = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (i_IE_redirect) begin
                  flush_id = 1'b1;
                  flush_ie = 1'b1;
               end else if (lu_hit) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  flush_ie = 1'b1;
                  if (LOAD_LATENCY > 1) begin
                     state_d  = LU_STALL;
                     lu_cnt_d = LuCntInit;
                  end
               end
            end
            LU_STALL: begin
               if (i_IE_redirect) begin
                  // Remaining bubbles are moot once the younger instructions are flushed
                  flush_id = 1'b1;
                  flush_ie = 1'b1;
                  state_d  = RUN;
                  lu_cnt_d = '0;
               end else begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  flush_ie = 1'b1;
                  if (lu_cnt_q <= LuCntWidth'(1)) begin
                     state_d  = RUN;
                     lu_cnt_d = '0;
                  end else begin
                     lu_cnt_d = lu_cnt_q - LuCntWidth'(1);
                  end
               end
            end
            default: begin
               state_d  = RUN;
               lu_cnt_d = '0;
            end
         endcase
      end
   end

   // Saturating stall-cycle counter; clear wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (i_cnt_clr) begin
         cnt_d = '0;
      end else if (stall_if && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // State, bubble count and stall counter registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= RUN;
         lu_cnt_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         lu_cnt_q <= lu_cnt_d;
         cnt_q    <= cnt_d;
      end
   end

   assign o_fwd_sel_1    = i_reset ? FWD_RF : sel_1;
   assign o_fwd_sel_2    = i_reset ? FWD_RF : sel_2;
   assign o_stall_IF     = stall_if;
   assign o_stall_ID     = stall_id;
   assign o_stall_IE     = stall_ie;
   assign o_stall_IM     = stall_im;
   assign o_flush_ID     = flush_id;
   assign o_flush_IE     = flush_ie;
   assign o_flush_WB     = flush_wb;
   assign o_stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations
// per cycle, the monitor pops and compares them mid-cycle.
module tb_hazard_ctrl;

   localparam int unsigned RW = 5;
   localparam int unsigned CW = 4;

   typedef struct packed {
      logic [1:0]    f1;
      logic [1:0]    f2;
      logic [3:0]    st;   // {IF, ID, IE, IM}
      logic [2:0]    fl;   // {ID, IE, WB}
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] id_s1, id_s2, ie_s1, ie_s2, ie_d, im_d, wb_d;
   logic          id_u1, id_u2, ie_wr, im_wr, wb_wr, ie_ld, redir, busy, clr;
   logic [1:0]    f1, f2;
   logic          s_if, s_id, s_ie, s_im, fl_id, fl_ie, fl_wb;
   logic [CW-1:0] cnt;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .REG_ADDR_WIDTH (RW),
      .LOAD_LATENCY   (3),
      .CNT_WIDTH      (CW)
   ) dut (
      .i_clk               (clk),
      .i_reset             (rst),
      .i_ID_src_reg_1      (id_s1),
      .i_ID_src_reg_2      (id_s2),
      .i_ID_use_src_1      (id_u1),
      .i_ID_use_src_2      (id_u2),
      .i_IE_src_reg_1      (ie_s1),
      .i_IE_src_reg_2      (ie_s2),
      .i_IE_dst_reg        (ie_d),
      .i_IM_dst_reg        (im_d),
      .i_WB_dst_reg        (wb_d),
      .i_ctrl_IE_reg_wr_en (ie_wr),
      .i_ctrl_IM_reg_wr_en (im_wr),
      .i_ctrl_WB_reg_wr_en (wb_wr),
      .i_IE_is_load        (ie_ld),
      .i_IE_redirect       (redir),
      .i_dmem_busy         (busy),
      .i_cnt_clr           (clr),
      .o_fwd_sel_1         (f1),
      .o_fwd_sel_2         (f2),
      .o_stall_IF          (s_if),
      .o_stall_ID          (s_id),
      .o_stall_IE          (s_ie),
      .o_stall_IM          (s_im),
      .o_flush_ID          (fl_id),
      .o_flush_IE          (fl_ie),
      .o_flush_WB          (fl_wb),
      .o_stall_cycles      (cnt)
   );

   task automatic check(input string name, input string field, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s.%s got %0d expected %0d", name, field, act, exp);
      end
   endtask

   // Monitor: outputs are combinational, so every cycle presents one result
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check(n, "fwd1",  int'(f1), int'(e.f1));
         check(n, "fwd2",  int'(f2), int'(e.f2));
         check(n, "stall", int'({s_if, s_id, s_ie, s_im}), int'(e.st));
         check(n, "flush", int'({fl_id, fl_ie, fl_wb}), int'(e.fl));
         check(n, "cnt",   int'(cnt), int'(e.cnt));
      end
   end

   task automatic clear_in();
      id_s1 = '0; id_s2 = '0; ie_s1 = '0; ie_s2 = '0;
      ie_d  = '0; im_d  = '0; wb_d  = '0;
      id_u1 = 0; id_u2 = 0; ie_wr = 0; im_wr = 0; wb_wr = 0;
      ie_ld = 0; redir = 0; busy = 0; clr = 0;
   endtask

   // Load to x7 in IE with ID reading x7 through source 2
   task automatic set_lu();
      clear_in();
      ie_ld = 1; ie_wr = 1; ie_d = 5'd7; id_s2 = 5'd7; id_u2 = 1;
   endtask

   // Queue the expectation for the inputs currently applied, then advance one cycle
   task automatic step(input string name, input logic [1:0] ef1, input logic [1:0] ef2,
                       input logic [3:0] est, input logic [2:0] efl, input logic [CW-1:0] ecnt);
      exp_t e;
      e = '{f1: ef1, f2: ef2, st: est, fl: efl, cnt: ecnt};
      exp_q.push_back(e);
      name_q.push_back(name);
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_in();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;

      // Reset masks every output even with hazards present
      set_lu(); im_wr = 1; im_d = 5'd5; ie_s1 = 5'd5; redir = 0;
      step("reset", 2'b00, 2'b00, 4'b0000, 3'b000, 0);
      rst = 0;

      // Forwarding
      clear_in(); im_wr = 1; im_d = 5'd5; wb_wr = 1; wb_d = 5'd5; ie_s1 = 5'd5; ie_s2 = 5'd3;
      step("fwd_im", 2'b10, 2'b00, 4'b0000, 3'b000, 0);
      im_wr = 0;
      step("fwd_wb", 2'b01, 2'b00, 4'b0000, 3'b000, 0);
      clear_in(); im_wr = 1; wb_wr = 1;
      step("fwd_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 0);
      clear_in(); im_wr = 1; im_d = 5'd9; wb_wr = 1; wb_d = 5'd4; ie_s1 = 5'd4; ie_s2 = 5'd9;
      step("fwd_mix", 2'b01, 2'b10, 4'b0000, 3'b000, 0);

      // Redirect beats load-use: flush only, stays in RUN
      set_lu(); redir = 1;
      step("redir_lu", 2'b00, 2'b00, 4'b0000, 3'b110, 0);
      clear_in();
      step("redir_after", 2'b00, 2'b00, 4'b0000, 3'b000, 0);

      // Load-use, three bubbles, forwarding still live in LU_STALL
      set_lu();
      step("lu_b1", 2'b00, 2'b00, 4'b1100, 3'b010, 0);
      clear_in(); im_wr = 1; im_d = 5'd6; ie_s1 = 5'd6;
      step("lu_b2", 2'b10, 2'b00, 4'b1100, 3'b010, 1);
      clear_in();
      step("lu_b3", 2'b00, 2'b00, 4'b1100, 3'b010, 2);
      step("lu_done", 2'b00, 2'b00, 4'b0000, 3'b000, 3);

      // Unused source does not stall
      clear_in(); ie_ld = 1; ie_wr = 1; ie_d = 5'd7; id_s1 = 5'd7; id_u2 = 1;
      step("lu_unused", 2'b00, 2'b00, 4'b0000, 3'b000, 3);
      clear_in(); clr = 1;
      step("clr", 2'b00, 2'b00, 4'b0000, 3'b000, 3);

      // Freeze for 4 cycles from the second bubble, then 2 bubbles resume
      set_lu();
      step("busy_b1", 2'b00, 2'b00, 4'b1100, 3'b010, 0);
      clear_in(); busy = 1;
      step("busy_f1", 2'b00, 2'b00, 4'b1111, 3'b001, 1);
      step("busy_f2", 2'b00, 2'b00, 4'b1111, 3'b001, 2);
      step("busy_f3", 2'b00, 2'b00, 4'b1111, 3'b001, 3);
      step("busy_f4", 2'b00, 2'b00, 4'b1111, 3'b001, 4);
      busy = 0;
      step("busy_b2", 2'b00, 2'b00, 4'b1100, 3'b010, 5);
      step("busy_b3", 2'b00, 2'b00, 4'b1100, 3'b010, 6);
      step("busy_done", 2'b00, 2'b00, 4'b0000, 3'b000, 7);

      // Redirect aborts LU_STALL
      set_lu();
      step("abort_b1", 2'b00, 2'b00, 4'b1100, 3'b010, 7);
      clear_in(); redir = 1;
      step("abort_redir", 2'b00, 2'b00, 4'b0000, 3'b110, 8);
      clear_in();
      step("abort_after", 2'b00, 2'b00, 4'b0000, 3'b000, 8);

      // Reset mid-stall drops the remaining bubbles
      set_lu();
      step("rst_b1", 2'b00, 2'b00, 4'b1100, 3'b010, 8);
      clear_in(); rst = 1;
      step("rst_mid", 2'b00, 2'b00, 4'b0000, 3'b000, 0);
      rst = 0;
      step("rst_after1", 2'b00, 2'b00, 4'b0000, 3'b000, 0);
      step("rst_after2", 2'b00, 2'b00, 4'b0000, 3'b000, 0);

      // Saturation at all-ones; redirect under freeze is suppressed
      clear_in(); busy = 1;
      for (int i = 0; i < 17; i++) begin
         redir = (i == 2);
         step("sat", 2'b00, 2'b00, 4'b1111, 3'b001, (i < 15) ? CW'(i) : CW'(15));
      end
      redir = 0; clr = 1;
      step("sat_clr", 2'b00, 2'b00, 4'b1111, 3'b001, 15);
      clear_in();
      step("sat_zero", 2'b00, 2'b00, 4'b0000, 3'b000, 0);

      // Let the monitor drain, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
